// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size, reset defaults.
// Optional build macro ALIGN_CHECK_EN is consumed by fetch_pc_gen, not by this package.
package core_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [WORD_SIZE-1:0] RESET_VECTOR = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // True when a byte address is not aligned to an instruction boundary
  function automatic logic addr_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_pc_reg.sv
// Architectural fetch PC register: reset vector, redirect load, or sequential increment.
module pc_reg
  import core_pkg::*;
#(
  parameter int unsigned         WordSize    = WORD_SIZE,
  parameter logic [WordSize-1:0] ResetVector = WordSize'(RESET_VECTOR)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic [WordSize-1:0] load_addr,
  input  logic                inc,
  output logic [WordSize-1:0] pc_q,
  output logic [WordSize-1:0] pc_next_c
);

  // Next PC select: a load beats an increment; increment wraps modulo 2^WordSize
  always_comb begin
    pc_next_c = pc_q;
    if (load) begin
      pc_next_c = load_addr;
    end else if (inc) begin
      pc_next_c = pc_q + WordSize'(INSTR_BYTES);
    end
  end

  // PC state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= ResetVector;
    end else begin
      pc_q <= pc_next_c;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator: one outstanding imem request at a time,
// presents {pc, instr} to decode, and honours taken-branch redirects.
// Build macro ALIGN_CHECK_EN: adds fetch_misaligned and parks the fetcher on a
// misaligned redirect; otherwise redirect_addr[1:0] is forced to zero.
module fetch_pc_gen
  import core_pkg::*;
#(
  parameter int unsigned         WordSize    = WORD_SIZE,
  parameter logic [WordSize-1:0] ResetVector = WordSize'(RESET_VECTOR)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                redirect,
  input  logic [WordSize-1:0] redirect_addr,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                if_valid,
  output logic [WordSize-1:0] if_pc,
  output logic [WordSize-1:0] if_instr
`ifdef ALIGN_CHECK_EN
  ,
  output logic                fetch_misaligned
`endif
);

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic                squash_q;
  logic                squash_d;
  logic                pc_load;
  logic                pc_inc;
  logic                capture;
  logic                if_valid_d;
  logic                parked;
  logic                bad_align;
  logic [WordSize-1:0] pc_q;
  logic [WordSize-1:0] pc_next_c;
  logic [WordSize-1:0] load_addr;

`ifdef ALIGN_CHECK_EN
  assign bad_align = addr_misaligned(redirect_addr[1:0]);
  assign load_addr = redirect_addr;
  assign parked    = fetch_misaligned;

  // Sticky misalignment flag; only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_misaligned <= 1'b0;
    end else if (redirect && bad_align && !parked) begin
      fetch_misaligned <= 1'b1;
    end
  end
`else
  logic addr_lo_unused;

  assign bad_align      = 1'b0;
  assign parked         = 1'b0;
  assign load_addr      = {redirect_addr[WordSize-1:2], 2'b00};
  assign addr_lo_unused = ^redirect_addr[1:0];
`endif

  pc_reg #(
    .WordSize    (WordSize),
    .ResetVector (ResetVector)
  ) u_pc_reg (
    .clk       (clk),
    .rstn      (rstn),
    .load      (pc_load),
    .load_addr (load_addr),
    .inc       (pc_inc),
    .pc_q      (pc_q),
    .pc_next_c (pc_next_c)
  );

  // Next-state and datapath control; redirect overrides the normal flow
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    capture  = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = stall ? HOLD : REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_load = 1'b1;
      pc_inc  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
        REQ: begin
          // request already on the bus targets the old path
          state_d  = WAIT;
          squash_d = 1'b1;
        end
        WAIT: begin
          if (imem_ack) begin
            state_d  = REQ;
            squash_d = 1'b0;
          end else begin
            state_d  = WAIT;
            squash_d = 1'b1;
          end
        end
        default: begin
          state_d  = REQ;
          squash_d = 1'b0;
        end
      endcase
      if (bad_align) begin
        state_d  = IDLE;
        squash_d = 1'b0;
      end
    end

    // misaligned target seen: stop fetching until reset
    if (parked) begin
      state_d  = IDLE;
      squash_d = 1'b0;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      capture  = 1'b0;
    end
  end

  // Output slot stays live only while decode stalls, unless refilled
  assign if_valid_d = capture | (if_valid & stall & ~redirect);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Registered imem request and decode-facing outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= '0;
    end else begin
      imem_req <= (state_d == REQ);
      if (state_d == REQ) begin
        imem_addr <= pc_next_c;
      end
      if_valid <= if_valid_d;
      if (capture) begin
        if_pc    <= pc_q;
        if_instr <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios then randomized traffic,
// all compared against a transaction-level fetch model.
module tb_fetch_pc_gen;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_addr;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;
`ifdef ALIGN_CHECK_EN
  logic         fetch_misaligned;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
`ifdef ALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  // Instruction memory responder
  int           mem_cnt = 0;
  logic [W-1:0] mem_addr = '0;
  int unsigned  lat_min = 2;
  int unsigned  lat_max = 2;
  logic [W-1:0] salt;
  logic         force_ack = 1'b0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  // Reference model: where fetching goes next, what is outstanding, what decode sees
  logic         m_boot, m_issue, m_busy, m_stale, m_blocked, m_parked, m_valid;
  logic [W-1:0] m_addr, m_fetch, m_pc, m_instr;

  task automatic model_reset();
    m_boot = 1'b1; m_issue = 1'b0; m_busy = 1'b0; m_stale = 1'b0;
    m_blocked = 1'b0; m_parked = 1'b0; m_valid = 1'b0;
    m_addr = '0; m_fetch = 32'h0000_0000; m_pc = '0; m_instr = '0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [W-1:0] ra,
                            input logic ack, input logic [W-1:0] rd);
    logic nxt_issue;
    logic cap;
    logic misal;
    nxt_issue = 1'b0;
    cap       = 1'b0;
`ifdef ALIGN_CHECK_EN
    misal = (ra % 4) != 0;
`else
    misal = 1'b0;
`endif
    if (m_parked) begin
      nxt_issue = 1'b0;
    end else if (r) begin
      m_valid   = 1'b0;
      m_blocked = 1'b0;
      m_boot    = 1'b0;
      if (misal) begin
        m_parked = 1'b1;
        m_fetch  = ra;
        m_busy   = 1'b0;
        m_stale  = 1'b0;
      end else begin
        m_fetch = ra - (ra % 4);
        if (m_issue || (m_busy && !ack)) begin
          m_busy  = 1'b1;
          m_stale = 1'b1;
        end else begin
          m_busy    = 1'b0;
          m_stale   = 1'b0;
          nxt_issue = 1'b1;
        end
      end
    end else begin
      if (m_boot) begin
        m_boot    = 1'b0;
        nxt_issue = 1'b1;
      end else if (m_issue) begin
        m_busy = 1'b1;
      end else if (m_busy && ack) begin
        m_busy = 1'b0;
        if (m_stale) begin
          m_stale   = 1'b0;
          nxt_issue = 1'b1;
        end else begin
          cap = 1'b1;
        end
      end else if (m_blocked && !s) begin
        m_blocked = 1'b0;
        nxt_issue = 1'b1;
      end
      if (cap) begin
        m_pc    = m_fetch;
        m_instr = rd;
        m_fetch = m_fetch + 32'd4;
        m_valid = 1'b1;
        if (s) m_blocked = 1'b1;
        else   nxt_issue = 1'b1;
      end else begin
        m_valid = m_valid && s;
      end
    end
    m_issue = nxt_issue;
    if (nxt_issue) m_addr = m_fetch;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", W'(imem_req), W'(m_issue));
    if (m_issue) chk("imem_addr", imem_addr, m_addr);
    chk("if_valid", W'(if_valid), W'(m_valid));
    chk("if_pc", if_pc, m_pc);
    chk("if_instr", if_instr, m_instr);
`ifdef ALIGN_CHECK_EN
    chk("fetch_misaligned", W'(fetch_misaligned), W'(m_parked));
`endif
  endtask

  // One clock: check current outputs, drive this cycle's inputs, advance the model
  task automatic tick(input logic s, input logic r, input logic [W-1:0] ra);
    logic         ack;
    logic [W-1:0] rd;
    check_outputs();
    ack = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) ack = 1'b1;
    end
    rd = ack ? mem_word(mem_addr) : W'($urandom());
    if (imem_req) begin
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      mem_addr = imem_addr;
    end
    ack           = ack | force_ack;
    stall         = s;
    redirect      = r;
    redirect_addr = ra;
    imem_ack      = ack;
    imem_rdata    = rd;
    model_step(s, r, ra, ack, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [W-1:0] exp);
    int n;
    n = 0;
    tick(1'b0, 1'b0, '0);
    while (!imem_req && n < 30) begin
      tick(1'b0, 1'b0, '0);
      n++;
    end
    chk({tag, "_seen"}, W'(imem_req), W'(1));
    chk(tag, imem_addr, exp);
  endtask

  task automatic wait_mem(input int k);
    int n;
    n = 0;
    while (mem_cnt != k && n < 30) begin
      tick(1'b0, 1'b0, '0);
      n++;
    end
    chk("wait_mem", W'(mem_cnt), W'(k));
  endtask

  // Asynchronous reset mid-cycle with a stray ack on the bus
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_req", W'(imem_req), W'(0));
    chk("rst_addr", imem_addr, '0);
    chk("rst_valid", W'(if_valid), W'(0));
    chk("rst_pc", if_pc, '0);
    chk("rst_instr", if_instr, '0);
    stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    model_reset();
    mem_cnt = 0;
    rstn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic         s, r;
    salt = W'($urandom());
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    do_reset();

    // sequential fetch with ack two cycles after each request
    wait_req("req0", 32'h0);
    wait_req("req4", 32'h4);

    // decode stalls across capture of pc 0x4
    wait_mem(1);
    tick(1'b1, 1'b0, '0);
    repeat (5) tick(1'b1, 1'b0, '0);
    chk("hold_valid", W'(if_valid), W'(1));
    chk("hold_pc", if_pc, 32'h4);
    chk("hold_noreq", W'(imem_req), W'(0));
    wait_req("after_stall", 32'h8);

    // redirect while waiting on 0x8, ack due next cycle
    wait_mem(2);
    tick(1'b0, 1'b1, 32'h100);
    wait_req("redir_100", 32'h100);
    wait_mem(1);
    tick(1'b0, 1'b0, '0);
    chk("pc_100_valid", W'(if_valid), W'(1));
    chk("pc_100", if_pc, 32'h100);

    // redirect coincident with ack
    wait_mem(1);
    tick(1'b0, 1'b1, 32'h200);
    chk("same_cyc_req", W'(imem_req), W'(1));
    chk("same_cyc_addr", imem_addr, 32'h200);

    // PC wraps past the top of the address space
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req("wrap_fc", 32'hFFFF_FFFC);
    wait_req("wrap_0", 32'h0000_0000);

    // misaligned redirect target
    tick(1'b0, 1'b1, 32'h102);
`ifdef ALIGN_CHECK_EN
    repeat (8) tick(1'b0, 1'b0, '0);
    chk("misal_flag", W'(fetch_misaligned), W'(1));
    chk("misal_noreq", W'(imem_req), W'(0));
`else
    wait_req("align_strip", 32'h100);
`endif

    // reset during traffic, stray ack in the first idle cycle
    tick(1'b0, 1'b0, '0);
    do_reset();
    force_ack = 1'b1;
    tick(1'b0, 1'b0, '0);
    force_ack = 1'b0;
    chk("post_rst_req", W'(imem_req), W'(1));
    chk("post_rst_addr", imem_addr, 32'h0);

    // randomized stall/redirect/latency traffic
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      s  = ($urandom_range(9, 0) < 3);
      r  = ($urandom_range(19, 0) == 0);
      ra = W'($urandom());
      if ($urandom_range(3, 0) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
`ifdef ALIGN_CHECK_EN
      ra[1:0] = 2'b00;
`endif
      tick(s, r, ra);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
